xs_rom_req_server: RTL

- Responder side of the layer ROM fetch protocol used by the tilemap/sprite layers.
- Each layer issues a one-cycle `req` pulse with a byte address; this block latches it, arbitrates between clients and issues the read to the SDRAM controller port.
- It returns the 16-bit word to the requesting client with a one-cycle `rdy` pulse.
- Sits between the layer blocks (BACK1, BACK2, FRONT, OBJ) and the SDRAM controller, in the `clk_ram` domain.

---
 rtl/xs_rom_req_server.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/xs_rom_req_server.sv
// Layer ROM fetch responder: latches per-client requests, round-robin arbitrates,
// reads one word from the SDRAM port and returns it with a one-cycle cl_rdy pulse.
// Optional last-address cache per client is enabled by defining XS_ROMSRV_CACHE_EN.
module xs_rom_req_server #(
  parameter int NCLIENTS = 4,
  parameter int AW       = 25,
  parameter int DW       = 16
) (
  input  logic                   clk_ram,
  input  logic                   RESET,
  input  logic [NCLIENTS-1:0]    cl_req,
  input  logic [NCLIENTS*AW-1:0] cl_addr,
  output logic [NCLIENTS-1:0]    cl_rdy,
  output logic [NCLIENTS*DW-1:0] cl_data,
  output logic [AW-1:0]          mem_addr,
  output logic                   mem_rd,
  input  logic                   mem_ack,
  input  logic                   mem_valid,
  input  logic [DW-1:0]          mem_dout,
  output logic [1:0]             dbg_state
);

  localparam int IW = (NCLIENTS > 1) ? $clog2(NCLIENTS) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_HIT   = 2'd3;

  logic [1:0]          state;
  logic [NCLIENTS-1:0] req_q;
  logic [NCLIENTS-1:0] pend;
  logic [AW-1:0]       addr_q [NCLIENTS];
  logic [AW-1:0]       paddr  [NCLIENTS];
  logic [IW-1:0]       ptr;
  logic [IW-1:0]       gnt;
  logic [IW-1:0]       g_nxt;
  logic [IW-1:0]       idx;
  logic                found;
  logic                grant;
  logic                hit;
  logic                done_mem;

  assign dbg_state = state;

  always_ff @(posedge clk_ram or posedge RESET) begin
    if (RESET) begin
      req_q <= '0;
      for (int i = 0; i < NCLIENTS; i++) addr_q[i] <= '0;
    end else begin
      req_q <= cl_req;
      for (int i = 0; i < NCLIENTS; i++) addr_q[i] <= cl_addr[i*AW +: AW];
    end
  end

  // Round-robin: first pending client strictly after the last grant.
  always_comb begin
    found = 1'b0;
    g_nxt = ptr;
    idx   = '0;
    for (int k = 1; k <= NCLIENTS; k++) begin
      idx = IW'((int'(ptr) + k) % NCLIENTS);
      if (!found && pend[idx]) begin
        found = 1'b1;
        g_nxt = idx;
      end
    end
  end

  assign grant    = (state == S_IDLE) && found;
  assign done_mem = ((state == S_ISSUE) && mem_ack && mem_valid) ||
                    ((state == S_WAIT) && mem_valid);

`ifdef XS_ROMSRV_CACHE_EN
  logic [AW-1:0]       caddr [NCLIENTS];
  logic [NCLIENTS-1:0] cvalid;

  assign hit = cvalid[g_nxt] && (caddr[g_nxt] == paddr[g_nxt]);

  always_ff @(posedge clk_ram or posedge RESET) begin
    if (RESET) begin
      cvalid <= '0;
      for (int i = 0; i < NCLIENTS; i++) caddr[i] <= '0;
    end else if (done_mem) begin
      caddr[gnt]  <= mem_addr;
      cvalid[gnt] <= 1'b1;
    end
  end
`else
  assign hit = 1'b0;
`endif

  // A fresh request landing on the grant edge wins: the slot stays pending
  // with the new address while the grant carries the old one.
  always_ff @(posedge clk_ram or posedge RESET) begin
    if (RESET) begin
      pend <= '0;
      for (int i = 0; i < NCLIENTS; i++) paddr[i] <= '0;
    end else begin
      for (int i = 0; i < NCLIENTS; i++) begin
        if (req_q[i]) begin
          pend[i]  <= 1'b1;
          paddr[i] <= addr_q[i];
        end else if (grant && (g_nxt == IW'(i))) begin
          pend[i] <= 1'b0;
        end
      end
    end
  end

  // mem_rd/mem_addr form a valid/ready pair: both hold steady while mem_rd is
  // high, and the read is taken on the edge where mem_rd & mem_ack are both 1.
  always_ff @(posedge clk_ram or posedge RESET) begin
    if (RESET) begin
      state    <= S_IDLE;
      ptr      <= IW'(NCLIENTS - 1);
      gnt      <= '0;
      mem_rd   <= 1'b0;
      mem_addr <= '0;
      cl_rdy   <= '0;
      cl_data  <= '0;
    end else begin
      cl_rdy <= '0;
      case (state)
        S_IDLE: begin
          if (grant) begin
            ptr <= g_nxt;
            gnt <= g_nxt;
            if (hit) begin
              state <= S_HIT;
            end else begin
              mem_addr <= paddr[g_nxt];
              mem_rd   <= 1'b1;
              state    <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          if (mem_ack) begin
            mem_rd <= 1'b0;
            state  <= mem_valid ? S_IDLE : S_WAIT;
          end
        end
        S_WAIT: begin
          if (mem_valid) state <= S_IDLE;
        end
        S_HIT: begin
          cl_rdy[gnt] <= 1'b1;
          state       <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
      if (done_mem) begin
        cl_data[int'(gnt)*DW +: DW] <= mem_dout;
        cl_rdy[gnt]                 <= 1'b1;
      end
    end
  end

endmodule
